// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: DATA/STATUS bus registers, byte FIFO, 8N1 serialiser.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module uart_tx_port #(
  parameter logic [15:0] BASE_ADDR = 16'hff00,
  parameter logic [15:0] CLK_DIV   = 16'd434,
  parameter int unsigned FIFO_AW   = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] address_bus,
  inout  wire  [7:0]  data_bus,
  input  logic        r,
  input  logic        w,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned DEPTH     = 1 << FIFO_AW;
  localparam int unsigned CW        = FIFO_AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [15:0] CTRL_ADDR = BASE_ADDR + 16'd1;
  localparam logic [15:0] RELOAD    = CLK_DIV - 16'd1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic              hit0, hit1;
  logic              wr0, wr1, rd1;
  logic              wr0_q, wr1_q, rd1_q;
  logic              push, pop, flush, full, empty;
  logic              overrun_q;
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        rd_data_c;

  logic [2:0]        state_q, state_d;
  logic [15:0]       baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              baud_done;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  // Address decode and single-shot strobes (one action per held strobe)
  assign hit0 = (address_bus == BASE_ADDR);
  assign hit1 = (address_bus == CTRL_ADDR);
  assign wr0  = w & hit0 & ~wr0_q;
  assign wr1  = w & hit1 & ~wr1_q;
  assign rd1  = r & hit1 & ~rd1_q;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign flush = wr1 & data_bus[0];
  // A pop on the same edge frees a slot, so a write into a full FIFO is accepted then
  assign push  = wr0 & (~full | pop);

  assign rd_data_c = hit0 ? {4'b0, 4'(count_q)}
                          : {4'b0, overrun_q, full, empty, busy_q};
  assign data_bus  = (r & (hit0 | hit1)) ? rd_data_c : 8'bz;

  assign tx   = tx_q;
  assign busy = busy_q;

  // Strobe history and sticky overrun flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr0_q     <= 1'b0;
      wr1_q     <= 1'b0;
      rd1_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr0_q <= w & hit0;
      wr1_q <= w & hit1;
      rd1_q <= r & hit1;
      if (wr0 & full & ~pop) begin
        overrun_q <= 1'b1;
      end else if (rd1) begin
        overrun_q <= 1'b0;
      end
    end
  end

  // FIFO pointers and level; flush re-aligns the read pointer so stale slots are skipped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= wr_ptr_q;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      if (push & ~pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop & ~push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_bus;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign baud_done = (baud_q == 16'd0);

  // Transmit sequencer; tx/busy are computed from the next state so they stay registered
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
          baud_d  = RELOAD;
          shreg_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
          par_d   = ^mem_q[rd_ptr_q];
`endif
        end
      end
      S_START: begin
        if (baud_done) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          baud_d  = RELOAD;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = RELOAD;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_done) begin
          state_d = S_STOP;
          baud_d  = RELOAD;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (baud_done) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_START;
            baud_d  = RELOAD;
            shreg_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            par_d   = ^mem_q[rd_ptr_q];
`endif
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port with CLK_DIV=4: register vectors, frame shapes, overrun, flush, reset.
module tb_uart_tx_port;

  localparam logic [15:0] BASE = 16'hff00;
  localparam logic [15:0] A1   = 16'hff01;
  localparam int D = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] address_bus = 16'h0000;
  logic        r = 1'b0;
  logic        w = 1'b0;
  logic        tb_oe = 1'b0;
  logic [7:0]  tb_dat = 8'h00;
  wire  [7:0]  data_bus;
  logic        tx;
  logic        busy;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  assign data_bus = tb_oe ? tb_dat : 8'bz;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_port #(.BASE_ADDR(BASE), .CLK_DIV(16'd4), .FIFO_AW(3)) dut (
    .clk(clk), .reset_n(reset_n), .address_bus(address_bus), .data_bus(data_bus),
    .r(r), .w(w), .tx(tx), .busy(busy)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdat;
    logic        rd;
    logic        wr;
    logic        chk;
    logic [7:0]  exp;
  } vec_t;

  vec_t tv[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    address_bus = a;
    tb_dat = d;
    tb_oe = 1'b1;
    w = 1'b1;
    step();
    w = 1'b0;
    tb_oe = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input int exp, input string nm);
    address_bus = a;
    r = 1'b1;
    #1;
    chk(nm, int'(data_bus), exp);
    step();
    r = 1'b0;
  endtask

  // Waits (bounded) for a start bit, then checks each bit's first and last clock
  task automatic expect_frame(input logic [7:0] b, input int max_wait, input string nm);
    logic [10:0] seq;
    int k;
    seq = {1'b1, 1'b1, b, 1'b0};
`ifdef UART_TX_PARITY_EN
    seq[9] = ^b;
`endif
    k = 0;
    while (tx !== 1'b0 && k < max_wait) begin
      step();
      k++;
    end
    if (tx !== 1'b0) begin
      chk({nm, " start timeout"}, int'(tx), 0);
      return;
    end
    for (int i = 0; i < NB; i++) begin
      for (int c = 0; c < D; c++) begin
        if (c == 0 || c == D - 1)
          chk($sformatf("%s bit%0d c%0d {busy,tx}", nm, i, c), int'({busy, tx}), int'({1'b1, seq[i]}));
        step();
      end
    end
  endtask

  task automatic expect_quiet(input int n, input string nm);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) seen++;
      step();
    end
    chk(nm, seen, 0);
  endtask

  initial begin
    logic [7:0] wb [20];
    int k;
    int t1;

    tv[0]  = '{BASE,          8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
    tv[1]  = '{A1,            8'h00, 1'b1, 1'b0, 1'b1, 8'h02};
    tv[2]  = '{16'hff02,      8'h99, 1'b0, 1'b1, 1'b0, 8'h00};
    tv[3]  = '{BASE,          8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
    tv[4]  = '{A1,            8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    tv[5]  = '{A1,            8'h00, 1'b1, 1'b0, 1'b1, 8'h02};
    tv[6]  = '{16'hfe00,      8'h12, 1'b0, 1'b1, 1'b0, 8'h00};
    tv[7]  = '{BASE,          8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
    tv[8]  = '{BASE,          8'h80, 1'b0, 1'b1, 1'b0, 8'h00};
    tv[9]  = '{BASE,          8'h00, 1'b1, 1'b0, 1'b1, 8'h01};
    tv[10] = '{A1,            8'h00, 1'b1, 1'b0, 1'b1, 8'h03};
    tv[11] = '{BASE,          8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
    for (int i = 0; i < 20; i++) wb[i] = 8'(i * 37 + 3);

    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    step();
    chk("reset tx", int'(tx), 1);
    chk("reset busy", int'(busy), 0);

    // Register access vectors, one clock each
    for (int i = 0; i < 12; i++) begin
      address_bus = tv[i].addr;
      tb_dat = tv[i].wdat;
      tb_oe = tv[i].wr;
      r = tv[i].rd;
      w = tv[i].wr;
      #1;
      if (tv[i].chk) chk($sformatf("vec%0d rdata", i), int'(data_bus), int'(tv[i].exp));
      step();
    end
    r = 1'b0;
    w = 1'b0;
    tb_oe = 1'b0;
    k = 0;
    while (busy && k < 200) begin
      step();
      k++;
    end
    chk("vec drain busy", int'(busy), 0);

    // Push/pop latency and a full 0x55 frame
    wr(BASE, 8'h55);
    chk("lat tx before pop", int'(tx), 1);
    chk("lat busy before pop", int'(busy), 0);
    rd(BASE, 1, "lat count");
    chk("lat tx after pop", int'(tx), 0);
    expect_frame(8'h55, 0, "f55");
    chk("f55 busy after stop", int'(busy), 0);
    chk("f55 tx after stop", int'(tx), 1);

    // Strobe held for five clocks gives exactly one frame
    fork
      begin
        address_bus = BASE;
        tb_dat = 8'h41;
        tb_oe = 1'b1;
        w = 1'b1;
        repeat (5) step();
        w = 1'b0;
        tb_oe = 1'b0;
      end
      expect_frame(8'h41, 4, "f41");
    join
    expect_quiet(60, "f41 single frame");
    rd(BASE, 0, "f41 count");

    // Back-to-back frames with no idle gap
    fork
      begin
        wr(BASE, 8'hA5);
        step();
        wr(BASE, 8'h3C);
        step();
      end
      begin
        expect_frame(8'hA5, 4, "fA5");
        expect_frame(8'h3C, 0, "f3C");
      end
    join
    chk("b2b busy end", int'(busy), 0);

    // Flush mid-frame: current frame completes, queued bytes vanish
    fork
      begin
        wr(BASE, 8'h11);
        step();
        wr(BASE, 8'h22);
        step();
        wr(BASE, 8'h33);
        step();
        rd(BASE, 2, "flush pre count");
        wr(A1, 8'h01);
        step();
        rd(BASE, 0, "flush count");
      end
      expect_frame(8'h11, 4, "f11");
    join
    chk("flush busy end", int'(busy), 0);
    expect_quiet(60, "flush no more frames");

    // Overrun: ten writes while the first frame is in the shifter
    wr(BASE, 8'h01);
    t1 = cyc;
    step();
    for (int i = 2; i <= 10; i++) begin
      wr(BASE, 8'(i));
      step();
    end
    rd(BASE, 8, "ov count");
    rd(A1, 8'h0D, "ov status");
    step();
    rd(A1, 8'h05, "ov status cleared");
    wr(A1, 8'h01);
    step();
    rd(BASE, 0, "ov flushed count");
    rd(A1, 8'h03, "ov flushed status");
    k = 0;
    while (busy && k < 200) begin
      step();
      k++;
    end
    chk("ov frame length", cyc - t1, 41);

    // Twenty bytes in bursts: pointers wrap twice
    fork
      begin
        for (int b = 0; b < 4; b++) begin
          for (int j = 0; j < 5; j++) begin
            wr(BASE, wb[b * 5 + j]);
            step();
          end
          repeat (170) step();
        end
      end
      begin
        for (int i = 0; i < 20; i++) expect_frame(wb[i], 400, $sformatf("wrap%0d", i));
      end
    join
    chk("wrap busy end", int'(busy), 0);

    // Asynchronous reset in the middle of a data bit
    wr(BASE, 8'h00);
    step();
    wr(BASE, 8'h77);
    step();
    wr(BASE, 8'h66);
    step();
    step();
    chk("mid tx data0", int'(tx), 0);
    chk("mid busy", int'(busy), 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async rst tx", int'(tx), 1);
    chk("async rst busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    step();
    rd(BASE, 0, "post rst count");
    rd(A1, 8'h02, "post rst status");
    expect_quiet(60, "post rst quiet");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
